// File: rtl/timer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | timer_pkg : run-state encoding and clock-derived divider constants       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } run_state_e;

  localparam int unsigned CLK_HZ_DEFAULT = 100_000_000;

  function automatic int unsigned hz_to_div(input int unsigned clk_hz, input int unsigned hz);
    return clk_hz / hz;
  endfunction

  // Counters must be at least one bit wide even for degenerate divisors.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned ONE_HZ_DIV = hz_to_div(CLK_HZ_DEFAULT, 1);
  localparam int unsigned TEN_HZ_DIV = hz_to_div(CLK_HZ_DEFAULT, 10);

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | btn_debounce : 2-flop synchroniser, stability counter, one-cycle press   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module btn_debounce
  import timer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  localparam int unsigned   CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;

  always_comb begin
    sync_d  = {sync_q[0], btn_raw};
    cnt_d   = cnt_q;
    level_d = level_q;
    // Any return to the accepted level restarts the stability window.
    if (sync_q[1] == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = sync_q[1];
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    press_d = level_d & ~level_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule
`default_nettype wire

// File: rtl/timer_run_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | timer_run_ctrl : button debounce, IDLE/RUN/PAUSE/DONE control and Tick   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module timer_run_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned CLK_HZ          = CLK_HZ_DEFAULT,
  parameter int unsigned TICK_DIV_SLOW   = hz_to_div(CLK_HZ, 1),
  parameter int unsigned TICK_DIV_FAST   = hz_to_div(CLK_HZ, 10),
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Btn_StartStop,
  input  logic       Btn_Clear,
  input  logic       Clk_Select,
  input  logic       TimerUpFlag,
  output logic       Tick,
  output logic       Count_Clear,
  output logic       Running,
  output logic [1:0] State
);

  localparam int unsigned   PW        = cnt_width(max_u(TICK_DIV_SLOW, TICK_DIV_FAST));
  localparam logic [PW-1:0] SLOW_LAST = PW'(TICK_DIV_SLOW - 1);
  localparam logic [PW-1:0] FAST_LAST = PW'(TICK_DIV_FAST - 1);

  logic start_press;
  logic clear_press;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_db_start (
    .clk     (Clk),
    .rst     (Rst),
    .btn_raw (Btn_StartStop),
    .press   (start_press)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_db_clear (
    .clk     (Clk),
    .rst     (Rst),
    .btn_raw (Btn_Clear),
    .press   (clear_press)
  );

  run_state_e    state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;
  logic          clr_q, clr_d;
  logic          running_q, running_d;
  logic [PW-1:0] div_last;
  logic          wrap;

  always_comb begin
    // Divisor follows Clk_Select live; >= catches a prescaler already past a shorter limit.
    div_last  = Clk_Select ? FAST_LAST : SLOW_LAST;
    wrap      = (presc_q >= div_last);
    state_d   = state_q;
    presc_d   = presc_q;
    tick_d    = 1'b0;
    clr_d     = 1'b0;
    if (clear_press) begin
      state_d = ST_IDLE;
      presc_d = '0;
      clr_d   = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_press) begin
            state_d = ST_RUN;
            presc_d = '0;
          end
        end
        ST_RUN: begin
          presc_d = wrap ? '0 : presc_q + PW'(1);
          // Tick is only issued while staying in RUN, so it never shows outside RUN.
          if (TimerUpFlag) begin
            state_d = ST_DONE;
          end else if (start_press) begin
            state_d = ST_PAUSE;
          end else begin
            tick_d = wrap;
          end
        end
        ST_PAUSE: begin
          if (start_press) begin
            state_d = ST_RUN;
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    running_d = (state_d == ST_RUN);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= ST_IDLE;
      presc_q   <= '0;
      tick_q    <= 1'b0;
      clr_q     <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      tick_q    <= tick_d;
      clr_q     <= clr_d;
      running_q <= running_d;
    end
  end

  assign Tick        = tick_q;
  assign Count_Clear = clr_q;
  assign Running     = running_q;
  assign State       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_timer_run_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_timer_run_ctrl : random buttons/flags against a window-based model    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_timer_run_ctrl;

  localparam int DEB  = 4;
  localparam int SLOW = 20;
  localparam int FAST = 2;
  localparam int N_RANDOM_CYCLES = 8000;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       Btn_StartStop;
  logic       Btn_Clear;
  logic       Clk_Select;
  logic       TimerUpFlag;
  logic       Tick;
  logic       Count_Clear;
  logic       Running;
  logic [1:0] State;

  always #5 Clk = ~Clk;

  timer_run_ctrl #(
    .CLK_HZ          (100),
    .TICK_DIV_SLOW   (SLOW),
    .TICK_DIV_FAST   (FAST),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .Btn_StartStop (Btn_StartStop),
    .Btn_Clear     (Btn_Clear),
    .Clk_Select    (Clk_Select),
    .TimerUpFlag   (TimerUpFlag),
    .Tick          (Tick),
    .Count_Clear   (Count_Clear),
    .Running       (Running),
    .State         (State)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, got, exp);
    end
  endtask

  // Reference model. A button's accepted level flips once the last DEB synchronised
  // samples (raw samples delayed two edges) all disagree with it; bit i of hist is
  // the raw value sampled i edges ago. Index 0 = Start/Stop, 1 = Clear.
  int hist [2];
  int lvl  [2];
  int prs  [2];
  int m_state, m_pre, m_tick, m_clr;

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      hist[b] = 0;
      lvl[b]  = 0;
      prs[b]  = 0;
    end
    m_state = M_IDLE;
    m_pre   = 0;
    m_tick  = 0;
    m_clr   = 0;
  endtask

  task automatic model_step(input int rst, input int raw_s, input int raw_c,
                            input int sel, input int up);
    int div, fire, raw, win, mask;
    if (rst != 0) begin
      model_reset();
      return;
    end
    m_tick = 0;
    m_clr  = 0;
    if (prs[1] != 0) begin
      m_state = M_IDLE;
      m_pre   = 0;
      m_clr   = 1;
    end else if (m_state == M_IDLE) begin
      if (prs[0] != 0) begin
        m_state = M_RUN;
        m_pre   = 0;
      end
    end else if (m_state == M_RUN) begin
      div   = (sel != 0) ? FAST : SLOW;
      fire  = (m_pre >= div - 1) ? 1 : 0;
      m_pre = (fire != 0) ? 0 : m_pre + 1;
      if (up != 0)          m_state = M_DONE;
      else if (prs[0] != 0) m_state = M_PAUSE;
      else                  m_tick  = fire;
    end else if (m_state == M_PAUSE) begin
      if (prs[0] != 0) m_state = M_RUN;
    end
    mask = (1 << DEB) - 1;
    for (int b = 0; b < 2; b++) begin
      raw     = (b == 0) ? raw_s : raw_c;
      hist[b] = ((hist[b] << 1) | raw) & 32'hFFFF;
      win     = (hist[b] >> 2) & mask;
      prs[b]  = 0;
      if (lvl[b] == 0 && win == mask) begin
        lvl[b] = 1;
        prs[b] = 1;
      end else if (lvl[b] == 1 && win == 0) begin
        lvl[b] = 0;
      end
    end
  endtask

  task automatic run_cycle();
    @(posedge Clk);
    model_step(int'(Rst), int'(Btn_StartStop), int'(Btn_Clear), int'(Clk_Select), int'(TimerUpFlag));
    #1;
    cyc++;
    check_val("State",       int'(State),       m_state);
    check_val("Tick",        int'(Tick),        m_tick);
    check_val("Count_Clear", int'(Count_Clear), m_clr);
    check_val("Running",     int'(Running),     (m_state == M_RUN) ? 1 : 0);
  endtask

  int seg_s, seg_c;

  initial begin
    Rst           = 1'b1;
    Btn_StartStop = 1'b1;
    Btn_Clear     = 1'b1;
    Clk_Select    = 1'b0;
    TimerUpFlag   = 1'b0;
    model_reset();

    // Reset held with both buttons pressed, then released with buttons still held.
    for (int i = 0; i < 3; i++) run_cycle();
    Rst = 1'b0;
    for (int i = 0; i < 4; i++) run_cycle();
    Btn_StartStop = 1'b0;
    Btn_Clear     = 1'b0;
    for (int i = 0; i < 8; i++) run_cycle();

    seg_s = 0;
    seg_c = 0;
    for (int i = 0; i < N_RANDOM_CYCLES; i++) begin
      if (seg_s == 0) begin
        Btn_StartStop = 1'($urandom_range(0, 1));
        // Mix sub-window bounces with presses long enough to be accepted.
        seg_s = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 60);
      end
      seg_s--;
      if (seg_c == 0) begin
        Btn_Clear = ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0;
        seg_c     = $urandom_range(1, 30);
      end
      seg_c--;
      if ($urandom_range(0, 59) == 0) Clk_Select = ~Clk_Select;
      TimerUpFlag = ($urandom_range(0, 79) == 0) ? 1'b1 : 1'b0;
      Rst         = ($urandom_range(0, 999) == 0) ? 1'b1 : 1'b0;
      run_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
